// File: rtl/issue_queue.sv
// Collapsing out-of-order issue queue: in-order allocate at the tail, issue the
// oldest entry whose two sources are ready, single wakeup broadcast per cycle.
module issue_queue #(
  parameter int DEPTH  = 8,
  parameter int PREG_W = 6,
  parameter int ROB_W  = 6,
  parameter int OP_W   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [OP_W-1:0]              disp_op,
  input  logic [PREG_W-1:0]            disp_prd,
  input  logic [PREG_W-1:0]            disp_prs1,
  input  logic [PREG_W-1:0]            disp_prs2,
  input  logic                         disp_rs1_rdy,
  input  logic                         disp_rs2_rdy,
  input  logic [ROB_W-1:0]             disp_rob_idx,
  input  logic                         wb_valid,
  input  logic [PREG_W-1:0]            wb_prd,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [OP_W-1:0]              issue_op,
  output logic [PREG_W-1:0]            issue_prd,
  output logic [PREG_W-1:0]            issue_prs1,
  output logic [PREG_W-1:0]            issue_prs2,
  output logic [ROB_W-1:0]             issue_rob_idx,
  output logic [$clog2(DEPTH):0]       count
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  // Handshakes: a transfer happens on an edge where valid and ready are both
  // high; disp_ready and issue_valid depend on registered state only.

  logic [DEPTH-1:0]  valid_q, rdy1_q, rdy2_q, valid_d, rdy1_d, rdy2_d;
  logic [OP_W-1:0]   op_q   [DEPTH];
  logic [OP_W-1:0]   op_d   [DEPTH];
  logic [PREG_W-1:0] prd_q  [DEPTH];
  logic [PREG_W-1:0] prd_d  [DEPTH];
  logic [PREG_W-1:0] prs1_q [DEPTH];
  logic [PREG_W-1:0] prs1_d [DEPTH];
  logic [PREG_W-1:0] prs2_q [DEPTH];
  logic [PREG_W-1:0] prs2_d [DEPTH];
  logic [ROB_W-1:0]  rob_q  [DEPTH];
  logic [ROB_W-1:0]  rob_d  [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d, tail;
  logic              sel_found, issue_fire, disp_fire;
  logic [IDX_W-1:0]  sel_idx;

  // Oldest-ready select: scanning downward leaves the lowest ready index.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && rdy1_q[i] && rdy2_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign disp_ready    = (count_q < CNT_W'(DEPTH));
  assign issue_valid   = sel_found;
  assign issue_op      = sel_found ? op_q[sel_idx]   : '0;
  assign issue_prd     = sel_found ? prd_q[sel_idx]  : '0;
  assign issue_prs1    = sel_found ? prs1_q[sel_idx] : '0;
  assign issue_prs2    = sel_found ? prs2_q[sel_idx] : '0;
  assign issue_rob_idx = sel_found ? rob_q[sel_idx]  : '0;
  assign count         = count_q;

  assign issue_fire = sel_found & issue_ready;
  assign disp_fire  = disp_valid & disp_ready;
  assign tail       = count_q - CNT_W'(issue_fire);

  // Collapse, then wakeup on the shifted image, then tail write with bypass.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_fire && (i >= int'(sel_idx))) begin
        valid_d[i] = (i == DEPTH - 1) ? 1'b0 : valid_q[IDX_W'(i + 1)];
        rdy1_d[i]  = rdy1_q[IDX_W'(i + 1)];
        rdy2_d[i]  = rdy2_q[IDX_W'(i + 1)];
        op_d[i]    = op_q[IDX_W'(i + 1)];
        prd_d[i]   = prd_q[IDX_W'(i + 1)];
        prs1_d[i]  = prs1_q[IDX_W'(i + 1)];
        prs2_d[i]  = prs2_q[IDX_W'(i + 1)];
        rob_d[i]   = rob_q[IDX_W'(i + 1)];
      end else begin
        valid_d[i] = valid_q[i];
        rdy1_d[i]  = rdy1_q[i];
        rdy2_d[i]  = rdy2_q[i];
        op_d[i]    = op_q[i];
        prd_d[i]   = prd_q[i];
        prs1_d[i]  = prs1_q[i];
        prs2_d[i]  = prs2_q[i];
        rob_d[i]   = rob_q[i];
      end
      if (wb_valid && valid_d[i]) begin
        if (prs1_d[i] == wb_prd) rdy1_d[i] = 1'b1;
        if (prs2_d[i] == wb_prd) rdy2_d[i] = 1'b1;
      end
      if (disp_fire && (tail == CNT_W'(i))) begin
        valid_d[i] = 1'b1;
        op_d[i]    = disp_op;
        prd_d[i]   = disp_prd;
        prs1_d[i]  = disp_prs1;
        prs2_d[i]  = disp_prs2;
        rob_d[i]   = disp_rob_idx;
        rdy1_d[i]  = disp_rs1_rdy | (wb_valid && (disp_prs1 == wb_prd));
        rdy2_d[i]  = disp_rs2_rdy | (wb_valid && (disp_prs2 == wb_prd));
      end
    end
    count_d = count_q;
    case ({disp_fire, issue_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]   <= '0;
        prd_q[i]  <= '0;
        prs1_q[i] <= '0;
        prs2_q[i] <= '0;
        rob_q[i]  <= '0;
      end
    end else begin
      valid_q <= flush ? '0 : valid_d;
      count_q <= flush ? '0 : count_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]   <= op_d[i];
        prd_q[i]  <= prd_d[i];
        prs1_q[i] <= prs1_d[i];
        prs2_q[i] <= prs2_d[i];
        rob_q[i]  <= rob_d[i];
      end
    end
  end
endmodule

// File: tb/tb_issue_queue.sv
// Directed + randomized bench for issue_queue; expected issues ({prd, rob_idx})
// are queued when entries are dispatched and popped when the DUT issues.
module tb_issue_queue;
  logic       clk = 1'b0;
  logic       reset, flush, disp_valid, disp_ready, disp_rs1_rdy, disp_rs2_rdy;
  logic [7:0] disp_op, issue_op;
  logic [5:0] disp_prd, disp_prs1, disp_prs2, disp_rob_idx, wb_prd;
  logic [5:0] issue_prd, issue_prs1, issue_prs2, issue_rob_idx;
  logic       wb_valid, issue_valid, issue_ready;
  logic [3:0] count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [11:0] exp_q[$];

  issue_queue #(.DEPTH(8), .PREG_W(6), .ROB_W(6), .OP_W(8)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_prd(disp_prd), .disp_prs1(disp_prs1), .disp_prs2(disp_prs2),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
    .disp_rob_idx(disp_rob_idx), .wb_valid(wb_valid), .wb_prd(wb_prd),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_prd(issue_prd), .issue_prs1(issue_prs1), .issue_prs2(issue_prs2),
    .issue_rob_idx(issue_rob_idx), .count(count)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [5:0] prd, input logic [5:0] prs1, input logic [5:0] prs2,
                          input logic r1, input logic r2, input logic [5:0] rob);
    disp_valid   = 1'b1;
    disp_op      = 8'($urandom_range(0, 255));
    disp_prd     = prd;
    disp_prs1    = prs1;
    disp_prs2    = prs2;
    disp_rs1_rdy = r1;
    disp_rs2_rdy = r2;
    disp_rob_idx = rob;
    tick();
    disp_valid = 1'b0;
  endtask

  task automatic wake(input logic [5:0] p);
    wb_valid = 1'b1;
    wb_prd   = p;
    tick();
    wb_valid = 1'b0;
  endtask

  // Wait (bounded) for an issue, compare it with the scoreboard head, let it fire.
  task automatic expect_issue(input string tag);
    logic [11:0] e;
    bit got;
    got = 1'b0;
    issue_ready = 1'b1;
    for (int c = 0; c < 10 && !got; c++) begin
      if (issue_valid) begin
        got = 1'b1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hfff;
        check(tag, 32'({issue_prd, issue_rob_idx}), 32'(e));
      end
      tick();
    end
    issue_ready = 1'b0;
    if (!got) check({tag, "_timeout"}, 32'(got), 32'd1);
  endtask

  initial begin
    logic [5:0] p, r;
    reset = 1'b1; flush = 1'b0; disp_valid = 1'b0; wb_valid = 1'b0; issue_ready = 1'b0;
    disp_op = '0; disp_prd = '0; disp_prs1 = '0; disp_prs2 = '0;
    disp_rs1_rdy = 1'b0; disp_rs2_rdy = 1'b0; disp_rob_idx = '0; wb_prd = '0;
    tick(); tick();
    check("rst_count", 32'(count), 32'd0);
    check("rst_disp_ready", 32'(disp_ready), 32'd1);
    check("rst_issue_valid", 32'(issue_valid), 32'd0);
    check("rst_issue_pay", 32'({issue_op, issue_prd, issue_rob_idx}), 32'd0);
    reset = 1'b0;
    tick();

    // ready dispatch: visible the cycle after dispatch, gone after the next edge
    issue_ready = 1'b1;
    exp_q.push_back({6'd10, 6'd5});
    dispatch(6'd10, 6'd3, 6'd4, 1'b1, 1'b1, 6'd5);
    check("ready_lat", 32'(issue_valid), 32'd1);
    expect_issue("ready_disp");
    check("ready_count", 32'(count), 32'd0);

    // wakeup ordering
    dispatch(6'd11, 6'd7, 6'd8, 1'b0, 1'b1, 6'd1);
    dispatch(6'd12, 6'd13, 6'd14, 1'b1, 1'b1, 6'd2);
    exp_q.push_back({6'd12, 6'd2});
    expect_issue("wake_b_first");
    check("wake_a_wait", 32'(issue_valid), 32'd0);
    wb_valid = 1'b1; wb_prd = 6'd7;
    #1 check("no_comb_wake", 32'(issue_valid), 32'd0);
    tick();
    wb_valid = 1'b0;
    check("wake_lat", 32'(issue_valid), 32'd1);
    exp_q.push_back({6'd11, 6'd1});
    expect_issue("wake_a");

    // dispatch bypass from a same-cycle writeback
    wb_valid = 1'b1; wb_prd = 6'd9;
    dispatch(6'd15, 6'd16, 6'd9, 1'b1, 1'b0, 6'd3);
    wb_valid = 1'b0;
    check("bypass_valid", 32'(issue_valid), 32'd1);
    exp_q.push_back({6'd15, 6'd3});
    expect_issue("bypass");

    // full queue, wake entry 3 in the middle, collapse
    for (int i = 0; i < 8; i++) dispatch(6'(30 + i), 6'(40 + i), 6'd50, 1'b0, 1'b1, 6'(i));
    check("full_count", 32'(count), 32'd8);
    check("full_ready", 32'(disp_ready), 32'd0);
    check("full_idle", 32'(issue_valid), 32'd0);
    dispatch(6'd60, 6'd61, 6'd62, 1'b1, 1'b1, 6'd63);
    check("full_reject", 32'(count), 32'd8);
    wake(6'd43);
    exp_q.push_back({6'd33, 6'd3});
    expect_issue("mid_issue");
    check("mid_count", 32'(count), 32'd7);
    wake(6'd40);
    check("dual_sel", 32'({issue_prd, issue_rob_idx}), 32'({6'd30, 6'd0}));
    issue_ready = 1'b1;
    dispatch(6'd38, 6'd48, 6'd50, 1'b0, 1'b1, 6'd8);
    issue_ready = 1'b0;
    check("dual_count", 32'(count), 32'd7);
    wake(6'd44);
    check("hold_sel", 32'(issue_rob_idx), 32'd4);
    wake(6'd41);
    check("older_sel", 32'(issue_rob_idx), 32'd1);
    wake(6'd42); wake(6'd45); wake(6'd46); wake(6'd47); wake(6'd48);
    foreach (exp_q[i]) check("sb_clean", 32'(exp_q.size()), 32'd0);
    for (int i = 1; i <= 8; i++)
      if (i != 3) exp_q.push_back({6'(30 + i), 6'(i)});
    for (int i = 0; i < 7; i++) expect_issue("collapse_order");
    check("drain_count", 32'(count), 32'd0);

    // flush with simultaneous dispatch and issue
    for (int i = 0; i < 5; i++) dispatch(6'(20 + i), 6'd1, 6'd2, 1'b1, 1'b1, 6'(10 + i));
    check("flush_pre_count", 32'(count), 32'd5);
    flush = 1'b1; issue_ready = 1'b1;
    dispatch(6'd25, 6'd1, 6'd2, 1'b1, 1'b1, 6'd15);
    flush = 1'b0; issue_ready = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_issue", 32'(issue_valid), 32'd0);
    check("flush_ready", 32'(disp_ready), 32'd1);
    tick();
    check("flush_absent", 32'({issue_valid, count}), 32'd0);

    // randomized ready entries drain oldest-first
    for (int i = 0; i < 6; i++) begin
      p = 6'($urandom_range(0, 63));
      r = 6'($urandom_range(0, 63));
      exp_q.push_back({p, r});
      dispatch(p, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1'b1, 1'b1, r);
    end
    for (int i = 0; i < 6; i++) expect_issue("rand_order");

    // asynchronous reset mid-cycle with three held entries
    for (int i = 0; i < 3; i++) dispatch(6'(i), 6'd55, 6'd56, 1'b0, 1'b0, 6'(i));
    check("areset_pre", 32'(count), 32'd3);
    #3 reset = 1'b1;
    #1;
    check("areset_count", 32'(count), 32'd0);
    check("areset_issue", 32'(issue_valid), 32'd0);
    check("areset_ready", 32'(disp_ready), 32'd1);
    #2 reset = 1'b0;
    tick();
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/issue_queue.md
# issue_queue

In-order-allocate, out-of-order-issue queue between the rename/ROB allocation stage and the execute units. Holds renamed instructions until both physical source operands are ready, then issues the oldest ready entry. Readiness is updated by a single writeback wakeup broadcast per cycle. The queue is collapsing: entry 0 is always the oldest, so age order is implicit in position.

## Interface
- DEPTH, 8: number of entries (power of two, ≥2).
- PREG_W, 6: physical register tag width.
- ROB_W, 6: ROB index width.
- OP_W, 8: opaque opcode/control payload width.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  synchronous clear of all entries (mispredict/exception).
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  queue can accept; equals (count < DEPTH).
- disp_op  in  OP_W  opcode payload.
- disp_prd  in  PREG_W  physical destination.
- disp_prs1, disp_prs2  in  PREG_W  physical sources.
- disp_rs1_rdy, disp_rs2_rdy  in  1  source already available at dispatch.
- disp_rob_idx  in  ROB_W  ROB slot of the instruction.
- wb_valid  in  1  wakeup broadcast valid.
- wb_prd  in  PREG_W  physical register written back.
- issue_valid  out  1  an entry is ready to issue.
- issue_ready  in  1  execute unit accepts.
- issue_op, issue_prd, issue_prs1, issue_prs2, issue_rob_idx  out  as above  payload of the selected entry.
- count  out  $clog2(DEPTH)+1  number of valid entries.

## Operation
- Entry fields: valid, op, prd, prs1, prs2, rdy1, rdy2, rob_idx. Valid entries are always contiguous at indices 0..count-1.
- Select: the lowest index k with valid & rdy1 & rdy2. issue_valid=1 iff such a k exists. The issue_* outputs carry entry k, and are all-zero when issue_valid=0.
- Issue fire = issue_valid & issue_ready. Entry k is removed, entries k+1..count-1 shift down one slot, and count decrements.
- Dispatch fire = disp_valid & disp_ready. The new entry is written at index count, or count-1 if an issue fires in the same cycle (post-collapse tail).
- Wakeup: when wb_valid is high, every valid entry with prs1==wb_prd sets rdy1, and likewise for prs2/rdy2. This applies to shifted entries as well.
- Dispatch bypass: a dispatching entry's rdyN = disp_rsN_rdy | (wb_valid & disp_prsN==wb_prd).
- Simultaneous dispatch + issue at count==DEPTH: disp_ready is 0, so no dispatch; the issue proceeds.
- Simultaneous dispatch + issue at count<DEPTH: count is unchanged.
- flush: on the next edge all valid bits clear and count=0. Dispatch, issue and wakeup in that cycle are discarded. The execute unit must ignore an issue handshake that coincides with flush.
- Payload fields are not cleared on removal; only the valid bits matter.

## Timing
- Reset values: count=0, disp_ready=1, issue_valid=0, all issue_* = 0, all valid/rdy bits 0.
- Reset is asynchronous mid-operation: the queue empties immediately and the outputs take their reset values without waiting for a clock edge.
- Dispatch-to-issue latency: minimum 1 cycle. An entry dispatched ready at edge N can have issue_valid=1 in cycle N and fire at edge N+1.
- Wakeup-to-issue: wakeup sampled at edge N makes the entry eligible in the cycle after N. There is no same-cycle combinational wakeup into select.
- disp_ready, issue_valid and issue_* are functions of registered state only, with no combinational path from disp_valid, wb_* or issue_ready. issue_* may be combinationally selected from registered entries.
- Holding issue_ready=0 keeps the same entry selected, unless an older entry becomes ready. In that case the selection changes to the older entry; issue_valid never drops while an entry remains ready.
- One dispatch, one issue and one wakeup are handled per cycle.

## Test plan
- Reset/idle: assert reset mid-cycle with 3 entries held -> count=0, issue_valid=0 and disp_ready=1 immediately, before the next edge.
- Ready dispatch: dispatch prd=10, prs1=3, prs2=4, both rdy, rob_idx=5, issue_ready=1 -> the next cycle shows issue_valid=1, issue_prd=10, issue_rob_idx=5; after the edge, count=0.
- Wakeup ordering: dispatch A (prs1=7, not ready), then B (ready) -> B issues first. Then wb_prd=7 -> A has issue_valid=1 the cycle after the wakeup edge.
- Dispatch bypass: dispatch with prs2=9 not ready while wb_valid=1 and wb_prd=9 in the same cycle -> the entry issues the next cycle with no further wakeup.
- Full/collapse: fill 8 entries with rob_idx 0..7, all not ready -> disp_ready=0. Wake entry 3 -> rob_idx 3 issues, count=7, order of the remainder is 0,1,2,4,5,6,7. Dispatch + issue in the same cycle keeps count=7.
- Flush: with 5 entries, assert flush together with disp_valid and a firing issue -> next cycle count=0, issue_valid=0, and the dispatched instruction is absent.
